// File: rtl/err_sampler_pkg.sv
// err_sampler_pkg
//   Shared types and helpers for the error-polynomial sampler.
//   - state_e   : controller states (IDLE, SAMP_V, SAMP_E0, SAMP_E1, DRAIN, FIN)
//   - phase_e   : tag carried by every pipeline slot, selects the target BRAM
//   - V_*       : 2-bit sign-magnitude encodings of the ternary v samples
//   - ERR_*     : width of the centered-binomial e0/e1 samples
//   - popcount_low / v_decode : combinational helpers used by the pipeline
package err_sampler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SAMP_V  = 3'd1,
      ST_SAMP_E0 = 3'd2,
      ST_SAMP_E1 = 3'd3,
      ST_DRAIN   = 3'd4,
      ST_FIN     = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      PH_V  = 2'd0,
      PH_E0 = 2'd1,
      PH_E1 = 2'd2
   } phase_e;

   localparam logic [1:0] V_ZERO = 2'b00;
   localparam logic [1:0] V_POS  = 2'b01;
   localparam logic [1:0] V_NEG  = 2'b11;

   localparam int ERR_BITS     = 6;
   localparam int ERR_MAG_BITS = 5;
   localparam int WORD_BITS    = 64;

   // Number of ones in the low nbits of w. nbits is always a constant at the
   // call site, so this collapses to a plain adder tree.
   function automatic logic [ERR_BITS-1:0] popcount_low(input logic [WORD_BITS-1:0] w,
                                                        input int nbits);
      logic [ERR_BITS-1:0] c;
      c = '0;
      for (int i = 0; i < WORD_BITS; i++) begin
         if (i < nbits) c = c + ERR_BITS'(w[i]);
      end
      return c;
   endfunction

   // Ternary decode of the two low random bits. 2'b11 is rejected before it
   // reaches this decoder, so its value here is irrelevant.
   function automatic logic [1:0] v_decode(input logic [1:0] bits);
      logic [1:0] r;
      case (bits)
         2'b01:   r = V_POS;
         2'b10:   r = V_NEG;
         default: r = V_ZERO;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cbd_sample.sv
// cbd_sample
//   Two-stage sample pipeline shared by all three error polynomials.
//   Stage 1 registers popcount(a) and popcount(b) (or the decoded v value);
//   stage 2 registers the signed difference in sign-magnitude form.
//   Valid, phase tag and address travel alongside the data so a phase change
//   upstream never mis-routes a sample already in flight.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   in_valid/tag/addr  sample slot entering stage 1 (rejected words never enter)
//   in_word            random word for this slot
//   s1_valid           stage 1 occupied (used by the controller to detect drain)
//   out_valid/tag/addr stage 2 slot, drives the BRAM write demux
//   out_data           {sign, mag[4:0]} for e0/e1, {4'b0, v} for v
module cbd_sample
   import err_sampler_pkg::*;
#(
   parameter int ETA  = 21,
   parameter int LOGN = 13
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  phase_e               in_tag,
   input  logic [LOGN-1:0]      in_addr,
   input  logic [WORD_BITS-1:0] in_word,
   output logic                 s1_valid,
   output logic                 out_valid,
   output phase_e               out_tag,
   output logic [LOGN-1:0]      out_addr,
   output logic [ERR_BITS-1:0]  out_data
);

   phase_e              s1_tag;
   logic [LOGN-1:0]     s1_addr;
   logic [ERR_BITS-1:0] s1_pa;
   logic [ERR_BITS-1:0] s1_pb;

   logic                s1_neg;
   logic [ERR_BITS-1:0] s1_mag;
   logic [ERR_BITS-1:0] s2_data_d;

   // Stage 1: popcounts. The v decoder reuses s1_pa as its holding register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_tag   <= PH_V;
         s1_addr  <= '0;
         s1_pa    <= '0;
         s1_pb    <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_tag  <= in_tag;
            s1_addr <= in_addr;
            if (in_tag == PH_V) begin
               s1_pa <= {{(ERR_BITS-2){1'b0}}, v_decode(in_word[1:0])};
               s1_pb <= '0;
            end else begin
               s1_pa <= popcount_low(in_word, ETA);
               s1_pb <= popcount_low(in_word >> ETA, ETA);
            end
         end
      end
   end

   // Magnitude is computed as the non-negative difference, so a zero result
   // always carries sign 0 (no negative zero).
   always_comb begin
      s1_neg    = (s1_pb > s1_pa);
      s1_mag    = s1_neg ? (s1_pb - s1_pa) : (s1_pa - s1_pb);
      s2_data_d = s1_pa;
      if (s1_tag != PH_V) s2_data_d = {s1_neg, s1_mag[ERR_MAG_BITS-1:0]};
   end

   // Stage 2: sign-magnitude result plus routing information.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_tag   <= PH_V;
         out_addr  <= '0;
         out_data  <= '0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_tag  <= s1_tag;
            out_addr <= s1_addr;
            out_data <= s2_data_d;
         end
      end
   end

endmodule

// File: rtl/error_poly_sampler.sv
// error_poly_sampler
//   Fills the v, e0 and e1 error BRAMs (N entries each) from a 64-bit random
//   word stream. v is ternary, e0/e1 are centered-binomial with parameter ETA.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start                    single-cycle pulse, accepted only in IDLE/FIN
//   busy                     fill in progress
//   done                     fill complete, held until the next accepted start
//   rnd_data/valid/ready     random word stream
//   {v,e0,e1}_bram_wr_*      BRAM write ports (address, data, write enable)
//   state_dbg                current controller state (state_e encoding)
//
// Handshake: a random word is consumed on a rising edge where rnd_valid and
// rnd_ready are both high. rnd_ready depends only on the controller state,
// never on rnd_valid, and the producer must hold rnd_data stable while
// rnd_valid is high and rnd_ready is low.
module error_poly_sampler
   import err_sampler_pkg::*;
#(
   parameter int N    = 8192,
   parameter int LOGN = 13,
   parameter int ETA  = 21
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   input  logic [WORD_BITS-1:0] rnd_data,
   input  logic                 rnd_valid,
   output logic                 rnd_ready,
   output logic [LOGN-1:0]      v_bram_wr_addr,
   output logic [1:0]           v_bram_wr_data,
   output logic                 v_bram_wea,
   output logic [LOGN-1:0]      e0_bram_wr_addr,
   output logic [ERR_BITS-1:0]  e0_bram_wr_data,
   output logic                 e0_bram_wea,
   output logic [LOGN-1:0]      e1_bram_wr_addr,
   output logic [ERR_BITS-1:0]  e1_bram_wr_data,
   output logic                 e1_bram_wea,
   output logic [2:0]           state_dbg
);

   localparam logic [LOGN:0] CNT_LAST = (LOGN+1)'(N - 1);

   state_e              state_q;
   state_e              state_d;
   logic [LOGN:0]       cnt_q;
   logic                done_q;

   phase_e              cur_phase;
   logic                accept;
   logic                reject;
   logic                take;
   logic                last;
   logic                start_ok;

   logic                s1_valid;
   logic                out_valid;
   phase_e              out_tag;
   logic [LOGN-1:0]     out_addr;
   logic [ERR_BITS-1:0] out_data;

   always_comb begin
      rnd_ready = 1'b0;
      cur_phase = PH_V;
      case (state_q)
         ST_SAMP_V:  begin rnd_ready = 1'b1; cur_phase = PH_V;  end
         ST_SAMP_E0: begin rnd_ready = 1'b1; cur_phase = PH_E0; end
         ST_SAMP_E1: begin rnd_ready = 1'b1; cur_phase = PH_E1; end
         default:    begin rnd_ready = 1'b0; cur_phase = PH_V;  end
      endcase
   end

   assign accept   = rnd_valid & rnd_ready;
   // 2'b11 in the v phase is consumed but produces no sample.
   assign reject   = (state_q == ST_SAMP_V) && (rnd_data[1:0] == 2'b11);
   assign take     = accept & ~reject;
   assign last     = take && (cnt_q == CNT_LAST);
   assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_FIN));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_FIN: if (start) state_d = ST_SAMP_V;
         ST_SAMP_V:       if (last) state_d = ST_SAMP_E0;
         ST_SAMP_E0:      if (last) state_d = ST_SAMP_E1;
         ST_SAMP_E1:      if (last) state_d = ST_DRAIN;
         // Nothing enters the pipeline in DRAIN, so once stage 1 is empty the
         // stage 2 slot (if any) retires on this same edge.
         ST_DRAIN:        if (!s1_valid) state_d = ST_FIN;
         default:         state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_ok) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
         end else if (take) begin
            cnt_q <= last ? '0 : cnt_q + 1'b1;
         end
         if ((state_q == ST_DRAIN) && (state_d == ST_FIN)) done_q <= 1'b1;
      end
   end

   assign busy      = (state_q == ST_SAMP_V) || (state_q == ST_SAMP_E0) ||
                      (state_q == ST_SAMP_E1) || (state_q == ST_DRAIN);
   assign done      = done_q;
   assign state_dbg = state_q;

   cbd_sample #(
      .ETA  (ETA),
      .LOGN (LOGN)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (take),
      .in_tag    (cur_phase),
      .in_addr   (cnt_q[LOGN-1:0]),
      .in_word   (rnd_data),
      .s1_valid  (s1_valid),
      .out_valid (out_valid),
      .out_tag   (out_tag),
      .out_addr  (out_addr),
      .out_data  (out_data)
   );

   // Write demux: the tag on the stage 2 slot selects the BRAM.
   assign v_bram_wea      = out_valid && (out_tag == PH_V);
   assign e0_bram_wea     = out_valid && (out_tag == PH_E0);
   assign e1_bram_wea     = out_valid && (out_tag == PH_E1);
   assign v_bram_wr_addr  = out_addr;
   assign e0_bram_wr_addr = out_addr;
   assign e1_bram_wr_addr = out_addr;
   assign v_bram_wr_data  = out_data[1:0];
   assign e0_bram_wr_data = out_data;
   assign e1_bram_wr_data = out_data;

endmodule

// File: tb/tb_error_poly_sampler.sv
// tb_error_poly_sampler
//   Random-word fills of error_poly_sampler checked against a sample-level
//   model: each accepted word is turned into the expected BRAM write using
//   the ternary / centered-binomial rules, and queued per BRAM.
module tb_error_poly_sampler;
   import err_sampler_pkg::*;

   localparam int N    = 512;
   localparam int LOGN = 9;
   localparam int ETA  = 21;
   localparam int EW   = LOGN + 6;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic                start = 1'b0;
   logic                busy, done;
   logic [63:0]         rnd_data = '0;
   logic                rnd_valid = 1'b0;
   logic                rnd_ready;
   logic [LOGN-1:0]     v_bram_wr_addr, e0_bram_wr_addr, e1_bram_wr_addr;
   logic [1:0]          v_bram_wr_data;
   logic [5:0]          e0_bram_wr_data, e1_bram_wr_data;
   logic                v_bram_wea, e0_bram_wea, e1_bram_wea;
   logic [2:0]          state_dbg;

   error_poly_sampler #(.N(N), .LOGN(LOGN), .ETA(ETA)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .busy            (busy),
      .done            (done),
      .rnd_data        (rnd_data),
      .rnd_valid       (rnd_valid),
      .rnd_ready       (rnd_ready),
      .v_bram_wr_addr  (v_bram_wr_addr),
      .v_bram_wr_data  (v_bram_wr_data),
      .v_bram_wea      (v_bram_wea),
      .e0_bram_wr_addr (e0_bram_wr_addr),
      .e0_bram_wr_data (e0_bram_wr_data),
      .e0_bram_wea     (e0_bram_wea),
      .e1_bram_wr_addr (e1_bram_wr_addr),
      .e1_bram_wr_data (e1_bram_wr_data),
      .e1_bram_wea     (e1_bram_wea),
      .state_dbg       (state_dbg)
   );

   // ---------------- bookkeeping ----------------
   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0]   word_q[$];
   logic [EW-1:0] exp_v_q[$];
   logic [EW-1:0] exp_e0_q[$];
   logic [EW-1:0] exp_e1_q[$];
   logic [5:0]    got_v[N], got_e0[N], got_e1[N];
   logic [5:0]    ref_v[N], ref_e0[N], ref_e1[N];
   int            m_cnt[3];
   int            wr_cnt[3];
   int            extra_acc, spurious;
   int            first_acc_cyc, last_acc_cyc, first_wr_cyc, done_cyc, done_rises, start_cyc;
   bit            done_prev;

   function automatic logic [5:0] v_ref(input logic [1:0] b);
      if (b == 2'b01) return 6'b000001;
      if (b == 2'b10) return 6'b000011;
      return 6'b000000;
   endfunction

   function automatic logic [5:0] cbd_ref(input logic [63:0] w);
      int d;
      d = $countones(w[ETA-1:0]) - $countones(w[2*ETA-1:ETA]);
      if (d < 0) return {1'b1, 5'(-d)};
      return {1'b0, 5'(d)};
   endfunction

   task automatic reset_model();
      exp_v_q.delete();
      exp_e0_q.delete();
      exp_e1_q.delete();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i]  = 0;
         wr_cnt[i] = 0;
      end
      for (int i = 0; i < N; i++) begin
         got_v[i]  = 6'h3F;
         got_e0[i] = 6'h3F;
         got_e1[i] = 6'h3F;
      end
      extra_acc     = 0;
      spurious      = 0;
      first_acc_cyc = -1;
      last_acc_cyc  = -1;
      first_wr_cyc  = -1;
      done_cyc      = -1;
      done_rises    = 0;
   endtask

   // Phase is implied by how many samples each BRAM has already received.
   task automatic model_accept(input logic [63:0] w);
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
      if (m_cnt[0] < N) begin
         if (w[1:0] != 2'b11) begin
            exp_v_q.push_back({LOGN'(m_cnt[0]), v_ref(w[1:0])});
            m_cnt[0]++;
         end
      end else if (m_cnt[1] < N) begin
         exp_e0_q.push_back({LOGN'(m_cnt[1]), cbd_ref(w)});
         m_cnt[1]++;
      end else if (m_cnt[2] < N) begin
         exp_e1_q.push_back({LOGN'(m_cnt[2]), cbd_ref(w)});
         m_cnt[2]++;
      end else begin
         extra_acc++;
      end
   endtask

   task automatic sb_write(input int b, input logic [LOGN-1:0] a, input logic [5:0] d);
      logic [EW-1:0] e;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      case (b)
         0: begin
            if (exp_v_q.size() == 0) begin spurious++; return; end
            e = exp_v_q.pop_front();
            check("v_wr", {a, d}, e);
            got_v[a] = d;
         end
         1: begin
            if (exp_e0_q.size() == 0) begin spurious++; return; end
            e = exp_e0_q.pop_front();
            check("e0_wr", {a, d}, e);
            got_e0[a] = d;
         end
         default: begin
            if (exp_e1_q.size() == 0) begin spurious++; return; end
            e = exp_e1_q.pop_front();
            check("e1_wr", {a, d}, e);
            got_e1[a] = d;
         end
      endcase
      wr_cnt[b]++;
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         if (rnd_valid && rnd_ready) model_accept(rnd_data);
         if (v_bram_wea)  sb_write(0, v_bram_wr_addr,  {4'b0000, v_bram_wr_data});
         if (e0_bram_wea) sb_write(1, e0_bram_wr_addr, e0_bram_wr_data);
         if (e1_bram_wea) sb_write(2, e1_bram_wr_addr, e1_bram_wr_data);
         if (done && !done_prev) begin
            done_rises++;
            done_cyc = cyc;
         end
         done_prev = done;
      end else begin
         done_prev = 1'b0;
      end
   end

   // ---------------- stimulus ----------------
   // mode 0: all-zero words; mode 1: random with directed v/e0 prefixes;
   // mode 2: plain random. Exactly enough words for one fill are built.
   task automatic build_words(input int mode);
      logic [63:0] w;
      int vv;
      word_q.delete();
      vv = 0;
      if (mode == 1) begin
         logic [1:0] pre[5];
         pre[0] = 2'b11; pre[1] = 2'b01; pre[2] = 2'b11; pre[3] = 2'b10; pre[4] = 2'b00;
         for (int i = 0; i < 5; i++) begin
            w = {$urandom, $urandom};
            w[1:0] = pre[i];
            word_q.push_back(w);
         end
         vv = 3;
      end
      while (vv < N) begin
         w = (mode == 0) ? 64'h0 : {$urandom, $urandom};
         if (w[1:0] != 2'b11) vv++;
         word_q.push_back(w);
      end
      if (mode == 1) begin
         w = {$urandom, $urandom}; w[41:0] = 42'h1FFFFF;                 word_q.push_back(w);
         w = {$urandom, $urandom}; w[41:0] = {21'h1FFFFF, 21'h000000};  word_q.push_back(w);
         w = {$urandom, $urandom}; w[41:0] = {21'h1FFFFF, 21'h1FFFFF};  word_q.push_back(w);
      end
      for (int i = (mode == 1) ? 3 : 0; i < 2 * N; i++) begin
         w = (mode == 0) ? 64'h0 : {$urandom, $urandom};
         if (mode != 0 && $urandom_range(0, 15) == 0) begin
            if ($urandom_range(0, 1) == 1) w[20:0]  = 21'h1FFFFF;
            else                           w[41:21] = 21'h1FFFFF;
         end
         word_q.push_back(w);
      end
   endtask

   task automatic do_fill(input int duty, input int abort_addr, input bit poke_e1,
                          output bit aborted);
      int idx;
      int budget;
      bit poked;
      bit first;
      idx = 0; budget = 0; poked = 0; first = 1;
      aborted = 0;
      reset_model();
      @(posedge clk); #1;
      start = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      forever begin
         rnd_valid = (idx < word_q.size()) && ($urandom_range(0, 99) < duty);
         rnd_data  = rnd_valid ? word_q[idx] : {$urandom, $urandom};
         if (poke_e1 && !poked && m_cnt[1] == N && m_cnt[2] >= 8) begin
            start = 1'b1;
            poked = 1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (first) begin
            check("start_busy",   busy, 1);
            check("start_done0",  done, 0);
            check("start_ready",  rnd_ready, 1);
            first = 0;
         end
         if (rnd_valid && rnd_ready) idx++;
         if (abort_addr >= 0 && e0_bram_wea && e0_bram_wr_addr == LOGN'(abort_addr)) begin
            rst = 1'b0;
            #1;
            check("abort_outputs",
                  {busy, done, rnd_ready, v_bram_wea, e0_bram_wea, e1_bram_wea,
                   v_bram_wr_addr, e0_bram_wr_addr, e1_bram_wr_addr,
                   v_bram_wr_data, e0_bram_wr_data, e1_bram_wr_data, state_dbg}, 0);
            rnd_valid = 1'b0;
            start     = 1'b0;
            aborted   = 1;
            return;
         end
         if (done) begin
            #1;
            break;
         end
         budget++;
         if (budget > 40000) begin
            check("fill_timeout", done, 1);
            break;
         end
         @(posedge clk); #1;
      end
      rnd_valid = 1'b0;
      start     = 1'b0;
   endtask

   task automatic end_checks(input string tag);
      check({tag, "_v_cnt"},     wr_cnt[0], N);
      check({tag, "_e0_cnt"},    wr_cnt[1], N);
      check({tag, "_e1_cnt"},    wr_cnt[2], N);
      check({tag, "_q_left"},    exp_v_q.size() + exp_e0_q.size() + exp_e1_q.size(), 0);
      check({tag, "_extra_acc"}, extra_acc, 0);
      check({tag, "_spurious"},  spurious, 0);
      check({tag, "_done_once"}, done_rises, 1);
      check({tag, "_busy_low"},  busy, 0);
      check({tag, "_ready_low"}, rnd_ready, 0);
      check({tag, "_done_lat"},  done_cyc - last_acc_cyc, 3);
   endtask

   initial begin
      bit ab;
      int mism;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            {busy, done, rnd_ready, v_bram_wea, e0_bram_wea, e1_bram_wea,
             v_bram_wr_addr, e0_bram_wr_addr, e1_bram_wr_addr,
             v_bram_wr_data, e0_bram_wr_data, e1_bram_wr_data, state_dbg}, 0);
      rst = 1'b1;

      // all-zero words, continuous valid
      build_words(0);
      do_fill(100, -1, 0, ab);
      end_checks("zero");
      check("zero_first_acc",  first_acc_cyc - start_cyc, 1);
      check("zero_wr_latency", first_wr_cyc - first_acc_cyc, 2);
      check("zero_done_time",  done_cyc - start_cyc, 3 * N + 3);
      mism = 0;
      for (int i = 0; i < N; i++)
         if (got_v[i] != 6'h00 || got_e0[i] != 6'h00 || got_e1[i] != 6'h00) mism++;
      check("zero_contents", mism, 0);

      // random words with directed prefixes, continuous valid
      build_words(1);
      do_fill(100, -1, 0, ab);
      end_checks("rand");
      check("dir_v0",  got_v[0],  6'h01);
      check("dir_v1",  got_v[1],  6'h03);
      check("dir_v2",  got_v[2],  6'h00);
      check("dir_e0a", got_e0[0], 6'h15);
      check("dir_e0b", got_e0[1], 6'h35);
      check("dir_e0c", got_e0[2], 6'h00);
      for (int i = 0; i < N; i++) begin
         ref_v[i]  = got_v[i];
         ref_e0[i] = got_e0[i];
         ref_e1[i] = got_e1[i];
      end

      // same words, rnd_valid at 30% duty
      do_fill(30, -1, 0, ab);
      end_checks("duty");
      mism = 0;
      for (int i = 0; i < N; i++)
         if (got_v[i] != ref_v[i] || got_e0[i] != ref_e0[i] || got_e1[i] != ref_e1[i]) mism++;
      check("duty_same_contents", mism, 0);

      // reset in the middle of the e0 phase
      build_words(2);
      do_fill(100, N / 2, 0, ab);
      check("abort_hit", ab, 1);
      repeat (3) @(posedge clk);
      #1;
      check("abort_held_idle", {busy, done, rnd_ready, state_dbg}, 0);
      rst = 1'b1;

      // fresh fill with an ignored start pulse during SAMP_E1
      do_fill(100, -1, 1, ab);
      end_checks("poke");

      // start straight after done: refill from address 0
      build_words(2);
      do_fill(100, -1, 0, ab);
      end_checks("refill");
      check("refill_first_acc", first_acc_cyc - start_cyc, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
